// File: rtl/wc_pkg.sv
// Shared constants, FSM encoding and helpers for the WC_2_5 Z collector.
package wc_pkg;

  // Width of one Z sample on the pad bus
  localparam int DATA_W = 10;

  // Collector FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so it can size a counter directly
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wc_sync_fifo.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module wc_sync_fifo
  import wc_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Storage array holds data only and needs no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wc_z_collector.sv
// Receive side of the WC_2_5 Z bus: skips the core pipeline fill, packs
// PACK samples per word, tags frame ends and buffers words for the host.
module wc_z_collector
  import wc_pkg::*;
#(
  parameter int DATA_W      = wc_pkg::DATA_W,
  parameter int PACK        = 2,
  parameter int LAT         = 8,
  parameter int FRAME_WORDS = 4,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        z_in,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clr_ovf,
  output logic [PACK*DATA_W-1:0]   o_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic                     o_last,
  output logic                     busy,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
);

  localparam int WORD_W = PACK * DATA_W;
  localparam int SK_W   = clog2(LAT);
  localparam int PC_W   = clog2(PACK);
  localparam int FC_W   = clog2(FRAME_WORDS);
  localparam int CNT_W  = clog2(DEPTH) + 1;

  state_t            state_q;
  state_t            state_d;
  logic [SK_W-1:0]   scnt_q;
  logic [PC_W-1:0]   pcnt_q;
  logic [FC_W-1:0]   fcnt_q;
  logic [WORD_W-1:0] pack_q;
  logic [WORD_W-1:0] word_asm;
  logic              capture;
  logic              skip_done;
  logic              word_done;
  logic              frame_end;
  logic              vld_p0;
  logic [WORD_W-1:0] word_p0;
  logic              last_p0;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [WORD_W:0]   fifo_rdata;
  logic              pop;
  logic              drop;

  // Saturating 8-bit increment for the drop counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) return v + 8'd1;
    return v;
  endfunction

  assign skip_done = (scnt_q == SK_W'(LAT - 2));
  assign word_done = capture && (pcnt_q == PC_W'(PACK - 1));
  assign frame_end = (fcnt_q == FC_W'(FRAME_WORDS - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state; stop always wins once a run is active, start only counts in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SKIP;
      ST_SKIP:    if (stop) state_d = ST_IDLE;
                  else if (skip_done) state_d = ST_CAPTURE;
      ST_CAPTURE: if (stop) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy    = (state_q != ST_IDLE);
    capture = (state_q == ST_CAPTURE);
  end

  // Skip, pack-slot and frame counters plus the push-stage valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt_q <= '0;
      pcnt_q <= '0;
      fcnt_q <= '0;
      vld_p0 <= 1'b0;
    end else begin
      scnt_q <= (state_q == ST_SKIP) ? scnt_q + 1'b1 : '0;
      // A stop drops any partial word: the slot counter restarts from 0
      if (capture && !stop) pcnt_q <= word_done ? '0 : pcnt_q + 1'b1;
      else                  pcnt_q <= '0;
      if (state_d == ST_IDLE) fcnt_q <= '0;
      else if (word_done)     fcnt_q <= frame_end ? '0 : fcnt_q + 1'b1;
      vld_p0 <= word_done;
    end
  end

  // Completed word: slots already held plus the sample arriving this cycle
  always_comb begin
    word_asm = pack_q;
    word_asm[(PACK-1)*DATA_W +: DATA_W] = z_in;
  end

  // ---- stage p0: sample into pack slot, register completed word for the FIFO ----
  always_ff @(posedge clk) begin
    if (capture) pack_q[pcnt_q*DATA_W +: DATA_W] <= z_in;
    if (word_done) begin
      word_p0 <= word_asm;
      last_p0 <= frame_end;
    end
  end

  assign pop  = o_valid && o_ready;
  assign drop = vld_p0 && fifo_full && !pop;

  // ---- stage p1: FIFO write, overflow bookkeeping ----
  wc_sync_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p0),
    .wdata ({last_p0, word_p0}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Sticky overflow flag and drop counter; a drop beats a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      drop_cnt <= sat_inc8(clr_ovf ? 8'd0 : drop_cnt, drop);
    end
  end

  // Head of FIFO is presented directly; outputs read zero while it is empty
  assign o_valid = (fifo_cnt != '0);
  assign o_data  = fifo_empty ? '0 : fifo_rdata[WORD_W-1:0];
  assign o_last  = !fifo_empty && fifo_rdata[WORD_W];

endmodule

// File: tb/tb_wc_z_collector.sv
// Self-checking bench for wc_z_collector: vector table plus scoreboard queue.
`timescale 1ns/1ps
module tb_wc_z_collector;

  localparam int DATA_W      = 10;
  localparam int PACK        = 2;
  localparam int LAT         = 8;
  localparam int FRAME_WORDS = 4;
  localparam int DEPTH       = 8;
  localparam int WORD_W      = PACK * DATA_W;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] z_in;
  logic              start;
  logic              stop;
  logic              clr_ovf;
  logic [WORD_W-1:0] o_data;
  logic              o_valid;
  logic              o_ready;
  logic              o_last;
  logic              busy;
  logic              ovf;
  logic [7:0]        drop_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wc_z_collector #(
    .DATA_W      (DATA_W),
    .PACK        (PACK),
    .LAT         (LAT),
    .FRAME_WORDS (FRAME_WORDS),
    .DEPTH       (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .z_in     (z_in),
    .start    (start),
    .stop     (stop),
    .clr_ovf  (clr_ovf),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_last   (o_last),
    .busy     (busy),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] z0;
    logic [DATA_W-1:0] z1;
    logic [WORD_W-1:0] exp_word;
    logic              exp_last;
  } vec_t;

  vec_t            vec [8];
  logic [WORD_W:0] exp_q [$];
  int              checks;
  int              errors;
  int              cyc;
  int              first_vld_cyc;
  int              t_last0;
  bit              seen_vld;
  bit              tog_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One clock: compare any handshake at the falling edge, then advance past the rising edge
  task automatic tick();
    logic [WORD_W:0] e;
    @(negedge clk);
    if (rst && o_valid && !seen_vld) begin
      seen_vld      = 1'b1;
      first_vld_cyc = cyc;
    end
    if (rst && o_valid && o_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got last=%0b data=%05h, required no word", o_last, o_data);
      end else begin
        e = exp_q.pop_front();
        if ({o_last, o_data} !== e) begin
          errors++;
          $display("FAIL word: got last=%0b data=%05h, required last=%0b data=%05h",
                   o_last, o_data, e[WORD_W], e[WORD_W-1:0]);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (tog_en) o_ready = ~o_ready;
  endtask

  task automatic get_word(input int src, input int i, output logic [DATA_W-1:0] s0,
                          output logic [DATA_W-1:0] s1, output logic [WORD_W:0] e);
    if (src == 0) begin
      s0 = vec[i].z0;
      s1 = vec[i].z1;
      e  = {vec[i].exp_last, vec[i].exp_word};
    end else begin
      s0 = DATA_W'(2 * i);
      s1 = DATA_W'(2 * i + 1);
      e  = {((i % FRAME_WORDS) == FRAME_WORDS - 1), s1, s0};
    end
  endtask

  // Capture run: start pulse, wait out the fill, nw words; ends one cycle after stop
  task automatic run(input int nw, input int src, input int keep, input bit extra_start,
                     input bit stop_slot0);
    logic [DATA_W-1:0] s0;
    logic [DATA_W-1:0] s1;
    logic [WORD_W:0]   e;
    start = 1'b1;
    tick();
    for (int k = 1; k < LAT; k++) begin
      start = (extra_start && k == 3);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < nw; i++) begin
      get_word(src, i, s0, s1, e);
      z_in  = s0;
      start = (extra_start && i == 0);
      tick();
      start = 1'b0;
      z_in  = s1;
      stop  = (i == nw - 1) && !stop_slot0;
      if (i < keep) exp_q.push_back(e);
      if (i == 0) t_last0 = cyc;
      tick();
      stop = 1'b0;
    end
    if (stop_slot0) begin
      z_in = 10'h155;
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_valid"}, o_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec[0] = '{10'h000, 10'h001, 20'h00400, 1'b0};
    vec[1] = '{10'h002, 10'h003, 20'h00C02, 1'b0};
    vec[2] = '{10'h004, 10'h005, 20'h01404, 1'b0};
    vec[3] = '{10'h006, 10'h007, 20'h01C06, 1'b1};
    vec[4] = '{10'h3FF, 10'h3FF, 20'hFFFFF, 1'b0};
    vec[5] = '{10'h155, 10'h2AA, 20'hAA955, 1'b0};
    vec[6] = '{10'h2AA, 10'h155, 20'h556AA, 1'b0};
    vec[7] = '{10'h3FF, 10'h000, 20'h003FF, 1'b1};

    checks = 0; errors = 0; cyc = 0; seen_vld = 1'b0; tog_en = 1'b0;
    first_vld_cyc = 0; t_last0 = 0;
    rst = 1'b0; z_in = '0; start = 1'b0; stop = 1'b0; clr_ovf = 1'b0; o_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b1;
    tick();

    // Reset in the middle of a capture with words waiting in the FIFO
    o_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (LAT - 1) tick();
    for (int i = 0; i < 8; i++) begin
      z_in = DATA_W'(i);
      tick();
    end
    chk("t1_valid_before_rst", o_valid, 1);
    chk("t1_busy_before_rst", busy, 1);
    rst = 1'b0;
    #1;
    chk("t1_valid", o_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_ovf", ovf, 0);
    tick();
    rst = 1'b1;
    o_ready = 1'b1;
    repeat (3) tick();
    chk("t1_valid_after", o_valid, 0);

    // Table run: counter words, pattern words, frame tags and first-word latency
    seen_vld = 1'b0;
    run(8, 0, 8, 1'b0, 1'b0);
    chk("t2_busy_after_stop_slot1", busy, 0);
    drain("t2_drain");
    chk("t2_latency", first_vld_cyc - t_last0, 2);

    // Extra start pulses in SKIP and CAPTURE must not shift alignment
    run(8, 0, 8, 1'b1, 1'b0);
    drain("t5_drain");

    // Stop on pack slot 0: the partial sample never becomes a word
    run(2, 0, 2, 1'b0, 1'b1);
    chk("t4_busy_after_stop_slot0", busy, 0);
    drain("t4_drain");

    // Overflow: ten words into an eight-deep FIFO with the consumer stalled
    o_ready = 1'b0;
    run(10, 1, 8, 1'b0, 1'b0);
    repeat (3) tick();
    chk("t3_ovf", ovf, 1);
    chk("t3_drop_cnt", drop_cnt, 2);
    chk("t3_valid", o_valid, 1);
    chk("t3_head", o_data, 20'h00400);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", ovf, 0);
    chk("t3_drop_clr", drop_cnt, 0);
    chk("t3_head_after_clr", o_data, 20'h00400);
    // Clear landing on the same edge as a drop
    run(1, 1, 0, 1'b0, 1'b0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr_vs_drop", ovf, 1);
    chk("t3_drop_clr_vs_drop", drop_cnt, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr2", ovf, 0);
    o_ready = 1'b1;
    drain("t3_drain");

    // Long run with a consumer that accepts every other cycle
    tog_en = 1'b1;
    run(40, 1, 40, 1'b0, 1'b0);
    drain("t6_drain");
    tog_en = 1'b0;
    o_ready = 1'b1;
    chk("t6_ovf", ovf, 0);
    chk("t6_drop_cnt", drop_cnt, 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
